serial_operand_shifter: RTL

//   Upstream feeder for the bit-serial adder. Accepts two WIDTH-bit operands over a

---
 rtl/serial_operand_shifter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/serial_operand_shifter.sv
// ---------------------------------------------------------------------------
// serial_operand_shifter
//
// Feeds a bit-serial adder. An operand pair (a, b) is accepted over a
// valid/ready handshake while idle, then driven out LSB-first on x/y, one bit
// per clock. The adder receives a one-cycle adder_clr pulse before bit 0 so
// its carry starts at zero. first_bit/last_bit frame the stream for the
// downstream sum collector.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous active-high reset
//   in_valid   in   1      operand pair presented on a/b
//   in_ready   out  1      shifter idle, will accept on the next edge
//   a          in   WIDTH  operand A, serialised on x
//   b          in   WIDTH  operand B, serialised on y
//   abort      in   1      drop the frame in progress (ignored while idle)
//   adder_clr  out  1      one-cycle clear for the adder, precedes bit 0
//   x          out  1      current serial bit of A
//   y          out  1      current serial bit of B
//   bit_valid  out  1      x/y carry a live operand bit
//   first_bit  out  1      x/y are bit 0
//   last_bit   out  1      x/y are bit WIDTH-1
//
// All outputs decode registered state only; nothing combinational reaches
// them from in_valid, a, b or abort.
// ---------------------------------------------------------------------------
module serial_operand_shifter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic             adder_clr,
    output logic             x,
    output logic             y,
    output logic             bit_valid,
    output logic             first_bit,
    output logic             last_bit
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [WIDTH-1:0] a_sh_reg, a_sh_next;
    logic [WIDTH-1:0] b_sh_reg, b_sh_next;

    // Right-shifted copies of the operand registers with zero fill at the MSB.
    logic [WIDTH-1:0] a_shr;
    logic [WIDTH-1:0] b_shr;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shr
            if (gi == WIDTH - 1) begin : g_msb
                assign a_shr[gi] = 1'b0;
                assign b_shr[gi] = 1'b0;
            end else begin : g_body
                assign a_shr[gi] = a_sh_reg[gi+1];
                assign b_shr[gi] = b_sh_reg[gi+1];
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            a_sh_reg  <= '0;
            b_sh_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            a_sh_reg  <= a_sh_next;
            b_sh_reg  <= b_sh_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        a_sh_next  = a_sh_reg;
        b_sh_next  = b_sh_reg;
        case (state_reg)
            IDLE: begin
                // abort has no meaning here, so it cannot block an accept.
                if (in_valid) begin
                    a_sh_next  = a;
                    b_sh_next  = b;
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                cnt_next = '0;
                if (abort) begin
                    a_sh_next  = '0;
                    b_sh_next  = '0;
                    state_next = IDLE;
                end else begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (abort || cnt_reg == CNT_LAST) begin
                    // End of frame or dropped frame: both leave the
                    // operand registers empty and the counter at zero.
                    a_sh_next  = '0;
                    b_sh_next  = '0;
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    a_sh_next = a_shr;
                    b_sh_next = b_shr;
                    cnt_next  = cnt_reg + CW'(1);
                end
            end
            default: begin
                a_sh_next  = '0;
                b_sh_next  = '0;
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        adder_clr = 1'b0;
        x         = 1'b0;
        y         = 1'b0;
        bit_valid = 1'b0;
        first_bit = 1'b0;
        last_bit  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
            end
            CLEAR: begin
                adder_clr = 1'b1;
            end
            SHIFT: begin
                x         = a_sh_reg[0];
                y         = b_sh_reg[0];
                bit_valid = 1'b1;
                first_bit = (cnt_reg == '0);
                last_bit  = (cnt_reg == CNT_LAST);
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

endmodule
